// File: rtl/sm_axil_param_loader.sv
// AXI4-Lite responder that streams signature and matrix words into the Sherman-Morrison core.
// Optional macro SM_LOADER_READBACK_EN: reads of 0x4/0x8 return the last accepted word.
module sm_axil_param_loader #(
    parameter int NUM_BANDS              = 16,
    parameter int CORRELATION_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH             = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [ADDR_WIDTH-1:0]                   s_axi_awaddr,
    input  logic                                    s_axi_awvalid,
    output logic                                    s_axi_awready,
    input  logic [31:0]                             s_axi_wdata,
    input  logic [3:0]                              s_axi_wstrb,
    input  logic                                    s_axi_wvalid,
    output logic                                    s_axi_wready,
    output logic [1:0]                              s_axi_bresp,
    output logic                                    s_axi_bvalid,
    input  logic                                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]                   s_axi_araddr,
    input  logic                                    s_axi_arvalid,
    output logic                                    s_axi_arready,
    output logic [31:0]                             s_axi_rdata,
    output logic [1:0]                              s_axi_rresp,
    output logic                                    s_axi_rvalid,
    input  logic                                    s_axi_rready,
    output logic [CORRELATION_DATA_WIDTH-1:0]       sig_data,
    output logic [$clog2(NUM_BANDS)-1:0]            sig_addr,
    output logic                                    sig_we,
    output logic [CORRELATION_DATA_WIDTH-1:0]       mat_data,
    output logic [$clog2(NUM_BANDS*NUM_BANDS)-1:0]  mat_addr,
    output logic                                    mat_we,
    output logic                                    core_enable
);

    localparam int MAT_WORDS = NUM_BANDS * NUM_BANDS;
    localparam int SIG_AW    = $clog2(NUM_BANDS);
    localparam int MAT_AW    = $clog2(MAT_WORDS);
    localparam int SIG_CW    = $clog2(NUM_BANDS + 1);
    localparam int MAT_CW    = $clog2(MAT_WORDS + 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_MATRIX = 2'd1,
        REG_SIG    = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_t;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

    wr_state_t         wr_state, wr_next;
    rd_state_t         rd_state, rd_next;

    reg_sel_t          aw_sel;
    logic              aw_held;
    logic              w_held;
    logic [31:0]       wdata_q;

    logic [SIG_CW-1:0] sig_cnt;
    logic [MAT_CW-1:0] mat_cnt;
    logic              sig_done;
    logic              mat_done;

    logic              exec;
    logic [1:0]        exec_resp;
    logic              sig_fire;
    logic              mat_fire;
    logic              ctrl_clear;
    logic              en_next;

    logic [31:0]       status_word;
    logic [31:0]       rd_word;
    logic [31:0]       sig_rb;
    logic [31:0]       mat_rb;
    logic              unused_bits;

    assign sig_done    = (sig_cnt == SIG_CW'(NUM_BANDS));
    assign mat_done    = (mat_cnt == MAT_CW'(MAT_WORDS));
    assign unused_bits = ^{s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        wr_next = wr_state;
        rd_next = rd_state;
        case (wr_state)
            WR_IDLE: if (aw_held && w_held) wr_next = WR_RESP;
            WR_RESP: if (s_axi_bready)      wr_next = WR_IDLE;
            default:                        wr_next = WR_IDLE;
        endcase
        case (rd_state)
            RD_IDLE: if (s_axi_arvalid) rd_next = RD_DATA;
            RD_DATA: if (s_axi_rready)  rd_next = RD_IDLE;
            default:                    rd_next = RD_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        s_axi_awready = !reset && !aw_held;
        s_axi_wready  = !reset && !w_held;
        s_axi_bvalid  = (wr_state == WR_RESP);
        s_axi_arready = !reset && (rd_state == RD_IDLE);
        s_axi_rvalid  = (rd_state == RD_DATA);
        exec          = (wr_state == WR_IDLE) && aw_held && w_held;
    end

    // AW and W are captured independently; both slots free together on the B handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_sel  <= REG_CTRL;
            wdata_q <= '0;
        end else begin
            if (s_axi_awvalid && s_axi_awready) begin
                aw_held <= 1'b1;
                aw_sel  <= reg_sel_t'(s_axi_awaddr[3:2]);
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_held  <= 1'b1;
                wdata_q <= s_axi_wdata;
            end
            if ((wr_state == WR_RESP) && s_axi_bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // Write decode: clear beats enable; an enabled core locks both loaders.
    always_comb begin
        exec_resp  = RESP_OKAY;
        sig_fire   = 1'b0;
        mat_fire   = 1'b0;
        ctrl_clear = 1'b0;
        en_next    = core_enable;
        case (aw_sel)
            REG_CTRL: begin
                if (wdata_q[1]) begin
                    ctrl_clear = 1'b1;
                end else if (wdata_q[0]) begin
                    if (sig_done && mat_done) en_next = 1'b1;
                    else                      exec_resp = RESP_SLVERR;
                end else begin
                    en_next = 1'b0;
                end
            end
            REG_MATRIX: begin
                if (core_enable || mat_done) exec_resp = RESP_SLVERR;
                else                         mat_fire  = 1'b1;
            end
            REG_SIG: begin
                if (core_enable || sig_done) exec_resp = RESP_SLVERR;
                else                         sig_fire  = 1'b1;
            end
            default: exec_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_axi_bresp <= RESP_OKAY;
            sig_we      <= 1'b0;
            sig_data    <= '0;
            sig_addr    <= '0;
            sig_cnt     <= '0;
            mat_we      <= 1'b0;
            mat_data    <= '0;
            mat_addr    <= '0;
            mat_cnt     <= '0;
            core_enable <= 1'b0;
        end else begin
            sig_we <= 1'b0;
            mat_we <= 1'b0;
            if (exec) begin
                s_axi_bresp <= exec_resp;
                if (ctrl_clear) begin
                    sig_cnt     <= '0;
                    mat_cnt     <= '0;
                    core_enable <= 1'b0;
                end else begin
                    core_enable <= en_next;
                end
                if (sig_fire) begin
                    sig_we   <= 1'b1;
                    sig_data <= wdata_q[CORRELATION_DATA_WIDTH-1:0];
                    sig_addr <= sig_cnt[SIG_AW-1:0];
                    sig_cnt  <= sig_cnt + SIG_CW'(1);
                end
                if (mat_fire) begin
                    mat_we   <= 1'b1;
                    mat_data <= wdata_q[CORRELATION_DATA_WIDTH-1:0];
                    mat_addr <= mat_cnt[MAT_AW-1:0];
                    mat_cnt  <= mat_cnt + MAT_CW'(1);
                end
            end
        end
    end

`ifdef SM_LOADER_READBACK_EN
    logic [CORRELATION_DATA_WIDTH-1:0] sig_shadow;
    logic [CORRELATION_DATA_WIDTH-1:0] mat_shadow;

    always_ff @(posedge clk) begin
        if (reset || (exec && ctrl_clear)) begin
            sig_shadow <= '0;
            mat_shadow <= '0;
        end else if (exec) begin
            if (sig_fire) sig_shadow <= wdata_q[CORRELATION_DATA_WIDTH-1:0];
            if (mat_fire) mat_shadow <= wdata_q[CORRELATION_DATA_WIDTH-1:0];
        end
    end

    assign sig_rb = 32'(sig_shadow);
    assign mat_rb = 32'(mat_shadow);
`else
    assign sig_rb = '0;
    assign mat_rb = '0;
`endif

    // Read data is snapshotted at the AR handshake and held until rready.
    always_comb begin
        status_word = {16'(mat_cnt), 8'(sig_cnt), 5'b0, core_enable, mat_done, sig_done};
        case (reg_sel_t'(s_axi_araddr[3:2]))
            REG_CTRL:   rd_word = {30'b0, 1'b0, core_enable};
            REG_MATRIX: rd_word = mat_rb;
            REG_SIG:    rd_word = sig_rb;
            default:    rd_word = status_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else if (s_axi_arvalid && s_axi_arready) begin
            s_axi_rdata <= rd_word;
            s_axi_rresp <= RESP_OKAY;
        end
    end

endmodule

// File: tb/tb_sm_axil_param_loader.sv
// Self-checking bench for sm_axil_param_loader: vector table, directed corner cases, random ops vs model.
module tb_sm_axil_param_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] sig_data;
    logic [3:0]  sig_addr;
    logic        sig_we;
    logic [31:0] mat_data;
    logic [7:0]  mat_addr;
    logic        mat_we;
    logic        core_enable;

    always #5 clk = ~clk;

    sm_axil_param_loader #(
        .NUM_BANDS(16),
        .CORRELATION_DATA_WIDTH(32),
        .ADDR_WIDTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .sig_data(sig_data), .sig_addr(sig_addr), .sig_we(sig_we),
        .mat_data(mat_data), .mat_addr(mat_addr), .mat_we(mat_we),
        .core_enable(core_enable)
    );

    int total = 0;
    int bad   = 0;

    // Strobe log filled by the monitor; the main process only reads it.
    logic [35:0] act_sig[$];
    logic [39:0] act_mat[$];
    int          sig_rd = 0;
    int          mat_rd = 0;

    always @(negedge clk) begin
        if (sig_we) act_sig.push_back({sig_addr, sig_data});
        if (mat_we) act_mat.push_back({mat_addr, mat_data});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int          m_sig = 0;
    int          m_mat = 0;
    bit          m_en  = 1'b0;
    logic [31:0] m_last_sig = '0;
    logic [31:0] m_last_mat = '0;
    logic [35:0] exp_sig[$];
    logic [39:0] exp_mat[$];

    function automatic void model_reset();
        m_sig = 0; m_mat = 0; m_en = 1'b0; m_last_sig = '0; m_last_mat = '0;
    endfunction

    function automatic logic [1:0] model_write(input logic [3:0] a, input logic [31:0] d);
        case (a[3:2])
            2'd0: begin
                if (d[1]) begin model_reset(); return 2'b00; end
                if (d[0]) begin
                    if (m_sig == 16 && m_mat == 256) begin m_en = 1'b1; return 2'b00; end
                    return 2'b10;
                end
                m_en = 1'b0;
                return 2'b00;
            end
            2'd1: begin
                if (m_en || m_mat == 256) return 2'b10;
                exp_mat.push_back({8'(m_mat), d});
                m_mat++; m_last_mat = d;
                return 2'b00;
            end
            2'd2: begin
                if (m_en || m_sig == 16) return 2'b10;
                exp_sig.push_back({4'(m_sig), d});
                m_sig++; m_last_sig = d;
                return 2'b00;
            end
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        case (a[3:2])
            2'd0: return {31'b0, m_en};
`ifdef SM_LOADER_READBACK_EN
            2'd1: return m_last_mat;
            2'd2: return m_last_sig;
`else
            2'd1: return 32'h0;
            2'd2: return 32'h0;
`endif
            default: return {16'(m_mat), 8'(m_sig), 5'b0, m_en, m_mat == 256, m_sig == 16};
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: handshake did not complete within the cycle bound", name);
    endtask

    task automatic check_strobes();
        logic [35:0] es, as_;
        logic [39:0] em, am;
        chk("sig_we count", 32'(act_sig.size() - sig_rd), 32'(exp_sig.size()));
        while (exp_sig.size() > 0) begin
            es = exp_sig.pop_front();
            if (sig_rd < act_sig.size()) begin
                as_ = act_sig[sig_rd]; sig_rd++;
                chk("sig_addr", 32'(as_[35:32]), 32'(es[35:32]));
                chk("sig_data", as_[31:0], es[31:0]);
            end
        end
        sig_rd = act_sig.size();
        chk("mat_we count", 32'(act_mat.size() - mat_rd), 32'(exp_mat.size()));
        while (exp_mat.size() > 0) begin
            em = exp_mat.pop_front();
            if (mat_rd < act_mat.size()) begin
                am = act_mat[mat_rd]; mat_rd++;
                chk("mat_addr", 32'(am[39:32]), 32'(em[39:32]));
                chk("mat_data", am[31:0], em[31:0]);
            end
        end
        mat_rd = act_mat.size();
    endtask

    // ---------------- bus tasks (entered and left at posedge+1) ----------------
    logic en_at_b;

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input int bdly,
                             output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        aw_done = 0; w_done = 0; n = 0; resp = 2'bxx;
        s_axi_awaddr = a; s_axi_awvalid = 1'b1;
        s_axi_wdata  = d; s_axi_wvalid  = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1; s_axi_awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1; s_axi_wvalid  = 1'b0; end
            n++;
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        if (!(aw_done && w_done)) begin timeout_fail("aw/w handshake"); return; end
        repeat (bdly) begin @(posedge clk); #1; end
        s_axi_bready = 1'b1;
        n = 0;
        while (!s_axi_bvalid && n < 50) begin @(posedge clk); #1; n++; end
        if (!s_axi_bvalid) begin timeout_fail("bvalid"); s_axi_bready = 1'b0; return; end
        en_at_b = core_enable;
        resp    = s_axi_bresp;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        n = 0; d = 'x; resp = 2'bxx;
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 50) begin @(posedge clk); #1; n++; end
        if (!s_axi_arready) begin timeout_fail("arready"); s_axi_arvalid = 1'b0; return; end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        n = 0;
        while (!s_axi_rvalid && n < 50) begin @(posedge clk); #1; n++; end
        if (!s_axi_rvalid) begin timeout_fail("rvalid"); s_axi_rready = 1'b0; return; end
        d = s_axi_rdata; resp = s_axi_rresp;
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic do_write(input string name, input logic [3:0] a, input logic [31:0] d,
                            input int bdly, output logic [1:0] r);
        logic [1:0] er;
        er = model_write(a, d);
        axi_write(a, d, bdly, r);
        chk({name, " bresp"}, 32'(r), 32'(er));
        check_strobes();
    endtask

    task automatic do_read(input string name, input logic [3:0] a, output logic [31:0] d);
        logic [1:0] r;
        axi_read(a, d, r);
        chk({name, " rdata"}, d, model_read(a));
        chk({name, " rresp"}, 32'(r), 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        model_reset();
        exp_sig.delete(); exp_mat.delete();
        sig_rd = act_sig.size(); mat_rd = act_mat.size();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] status;
    } vec_t;

    vec_t vecs[8];

    logic [1:0]  r;
    logic [31:0] rd;
    logic [31:0] d;
    logic [31:0] lastw;
    logic [3:0]  a;
    int          op;
    int          bd;

    initial begin
        vecs[0] = '{4'h0, 32'h0000_0001, 2'b10, 32'h0000_0000};
        vecs[1] = '{4'hC, 32'h0000_0005, 2'b10, 32'h0000_0000};
        vecs[2] = '{4'h8, 32'h0000_0011, 2'b00, 32'h0000_0100};
        vecs[3] = '{4'h4, 32'h0000_0022, 2'b00, 32'h0001_0100};
        vecs[4] = '{4'h0, 32'h0000_0003, 2'b00, 32'h0000_0000};
        vecs[5] = '{4'h8, 32'h0000_0033, 2'b00, 32'h0000_0100};
        vecs[6] = '{4'h0, 32'h0000_0000, 2'b00, 32'h0000_0100};
        vecs[7] = '{4'h0, 32'h0000_0001, 2'b10, 32'h0000_0100};

        reset = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = 4'hF;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0; en_at_b = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // Reset state
        chk("rst awready", 32'(s_axi_awready), 32'h0);
        chk("rst wready",  32'(s_axi_wready),  32'h0);
        chk("rst arready", 32'(s_axi_arready), 32'h0);
        chk("rst valids",  32'({s_axi_bvalid, s_axi_rvalid, sig_we, mat_we, core_enable}), 32'h0);
        chk("rst resp",    32'({s_axi_bresp, s_axi_rresp}), 32'h0);
        chk("rst rdata",   s_axi_rdata, 32'h0);
        chk("rst sig out", {sig_data[27:0], sig_addr}, 32'h0);
        chk("rst mat out", mat_data ^ 32'(mat_addr), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post-rst readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);

        // Table-driven register-map vectors
        for (int i = 0; i < 8; i++) begin
            do_write("vec", vecs[i].addr, vecs[i].data, i % 3, r);
            chk("vec table bresp", 32'(r), 32'(vecs[i].resp));
            do_read("vec status", 4'hC, rd);
            chk("vec table status", rd, vecs[i].status);
        end

        // Full load and enable
        do_reset();
        for (int i = 0; i < 16; i++) do_write("sig load", 4'h8, 32'd500000000, 0, r);
        do_write("sig 17th", 4'h8, 32'hDEAD_BEEF, 0, r);
        chk("sig 17th slverr", 32'(r), 32'h2);
        do_read("status sig full", 4'hC, rd);
        chk("status sig full const", rd, 32'h0000_1001);
        for (int i = 0; i < 256; i++) do_write("mat load", 4'h4, 32'd500000000, 0, r);
        do_write("mat 257th", 4'h4, 32'h1234_5678, 0, r);
        chk("mat 257th slverr", 32'(r), 32'h2);
        chk("enable before write", 32'(core_enable), 32'h0);
        do_write("enable", 4'h0, 32'h1, 0, r);
        chk("enable okay", 32'(r), 32'h0);
        chk("core_enable with bvalid", 32'(en_at_b), 32'h1);
        do_read("status loaded", 4'hC, rd);
        chk("status loaded const", rd, 32'h0100_1007);
        do_write("locked sig", 4'h8, 32'h0000_00AA, 0, r);
        chk("locked sig slverr", 32'(r), 32'h2);
        do_read("ctrl read", 4'h0, rd);
        chk("ctrl read const", rd, 32'h1);

        // Clear after enable
        do_write("clear", 4'h0, 32'h2, 0, r);
        chk("clear core_enable", 32'(core_enable), 32'h0);
        do_read("status cleared", 4'hC, rd);
        chk("status cleared const", rd, 32'h0);

        // AW three cycles ahead of W, bready held low five cycles
        s_axi_awaddr = 4'h8; s_axi_awvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        repeat (3) begin
            chk("early aw awready", 32'(s_axi_awready), 32'h0);
            chk("early aw bvalid", 32'(s_axi_bvalid), 32'h0);
            @(posedge clk); #1;
        end
        s_axi_wdata = 32'h5A5A_0001; s_axi_wvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0;
        chk("split bvalid early", 32'(s_axi_bvalid), 32'h0);
        @(posedge clk); #1;
        repeat (5) begin
            chk("split bvalid held", 32'(s_axi_bvalid), 32'h1);
            chk("split bresp held", 32'(s_axi_bresp), 32'h0);
            chk("split awready", 32'(s_axi_awready), 32'h0);
            @(posedge clk); #1;
        end
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        chk("split bvalid done", 32'(s_axi_bvalid), 32'h0);
        chk("split awready free", 32'(s_axi_awready), 32'h1);
        chk("split single strobe", 32'(act_sig.size() - sig_rd), 32'h1);
        if (act_sig.size() > sig_rd) chk("clear sig_addr 0", 32'(act_sig[sig_rd][35:32]), 32'h0);
        void'(model_write(4'h8, 32'h5A5A_0001));
        check_strobes();

        // Reset in the middle of matrix loading, with a write held
        for (int i = 0; i < 100; i++) do_write("mat partial", 4'h4, $urandom, 0, r);
        s_axi_awaddr = 4'h4; s_axi_awvalid = 1'b1; s_axi_wdata = 32'hFEED_0001; s_axi_wvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid-rst valids", 32'({s_axi_bvalid, s_axi_rvalid, sig_we, mat_we, core_enable}), 32'h0);
        chk("mid-rst readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h0);
        reset = 1'b0;
        model_reset();
        s_axi_bready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("aborted no bvalid", 32'(s_axi_bvalid), 32'h0);
        end
        s_axi_bready = 1'b0;
        check_strobes();
        do_read("status after abort", 4'hC, rd);
        chk("status after abort const", rd, 32'h0);
        lastw = '0;
        for (int i = 0; i < 256; i++) begin
            lastw = $urandom;
            do_write("mat reload", 4'h4, lastw, 0, r);
        end
        do_read("mat readback", 4'h4, rd);
`ifdef SM_LOADER_READBACK_EN
        chk("mat readback last", rd, lastw);
`else
        chk("mat readback zero", rd, 32'h0);
`endif

        // Randomized operations against the model
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            d  = $urandom;
            bd = $urandom_range(0, 3);
            if (op <= 3) begin
                do_write("rnd sig", 4'h8, d, bd, r);
            end else if (op <= 6) begin
                do_write("rnd mat", 4'h4, d, bd, r);
            end else if (op == 7) begin
                d = ($urandom_range(0, 7) == 0) ? 32'h2 : 32'($urandom_range(0, 1));
                do_write("rnd ctrl", 4'h0, d, bd, r);
            end else if (op == 8) begin
                do_write("rnd status wr", 4'hC, d, bd, r);
            end else begin
                a = 4'($urandom_range(0, 3) << 2);
                do_read("rnd read", a, rd);
            end
        end
        do_read("final status", 4'hC, rd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
